// File: rtl/wb_pkg.sv
// Shared types and helpers for the write-back arbiter.
package wb_pkg;
   localparam int REG_IDX_W = 5;
   localparam int XLEN_DEF  = 32;

   typedef struct packed {
      logic [REG_IDX_W-1:0] rd;
      logic [XLEN_DEF-1:0]  data;
   } wb_entry_t;

   function automatic logic [31:0] onehot32(input logic [REG_IDX_W-1:0] idx);
      onehot32 = 32'd1 << idx;
   endfunction
endpackage

// File: rtl/wb_chan_fifo.sv
// Per-channel result FIFO; per-slot valid/rd exported so the top can build pend_mask.
module wb_chan_fifo
   import wb_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int DEPTH = 2
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 push,
   input  logic [REG_IDX_W-1:0]                 push_rd,
   input  logic [XLEN-1:0]                      push_data,
   input  logic                                 pop,
   output logic                                 full,
   output logic                                 empty,
   output logic [REG_IDX_W-1:0]                 head_rd,
   output logic [XLEN-1:0]                      head_data,
   output logic [DEPTH-1:0]                     ent_vld,
   output logic [DEPTH-1:0][REG_IDX_W-1:0]      ent_rd
);
   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0]              wr_ptr, rd_ptr;
   logic [DEPTH-1:0][XLEN-1:0] mem_data;

   // Per-slot valid bits double as occupancy: full/empty fall out of them directly.
   assign full      = &ent_vld;
   assign empty     = ~|ent_vld;
   assign head_rd   = ent_rd[rd_ptr];
   assign head_data = mem_data[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         ent_vld <= '0;
         ent_rd  <= '0;
      end else begin
         if (push && !full) begin
            ent_vld[wr_ptr]  <= 1'b1;
            ent_rd[wr_ptr]   <= push_rd;
            mem_data[wr_ptr] <= push_data;
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (pop && !empty) begin
            ent_vld[rd_ptr] <= 1'b0;
            rd_ptr          <= rd_ptr + 1'b1;
         end
      end
   end
endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: EXE has fixed priority, long-latency channels drain round-robin.
// Optional perf counters under `define WB_PERF_EN.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NCH   = 2,
   parameter int DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      exe_vld,
   input  logic [REG_IDX_W-1:0]      exe_rd,
   input  logic [XLEN-1:0]           exe_data,
   input  logic [NCH-1:0]            lc_vld,
   input  logic [NCH*REG_IDX_W-1:0]  lc_rd,
   input  logic [NCH*XLEN-1:0]       lc_data,
   output logic [NCH-1:0]            lc_rdy,
   output logic                      rf_wr,
   output logic [REG_IDX_W-1:0]      rf_rd,
   output logic [XLEN-1:0]           rf_data,
   output logic [31:0]               pend_mask
`ifdef WB_PERF_EN
   ,
   output logic [31:0]               perf_starve_cnt,
   output logic [31:0]               perf_full_cnt
`endif
);
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

   logic [NCH-1:0]                             full, empty, push, pop;
   logic [NCH-1:0][REG_IDX_W-1:0]              head_rd;
   logic [NCH-1:0][XLEN-1:0]                   head_data;
   logic [NCH-1:0][DEPTH-1:0]                  ent_vld;
   logic [NCH-1:0][DEPTH-1:0][REG_IDX_W-1:0]   ent_rd;
   logic                                       exe_wr, cand_vld;
   logic [CW-1:0]                              rr_ptr, cand_idx;

   assign exe_wr = exe_vld && (exe_rd != '0);

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic [REG_IDX_W-1:0] rd_c;
      assign rd_c      = lc_rd[c*REG_IDX_W +: REG_IDX_W];
      assign lc_rdy[c] = !full[c] && !rst;
      // x0 results are acknowledged but never stored.
      assign push[c]   = lc_vld[c] && lc_rdy[c] && (rd_c != '0);
      assign pop[c]    = cand_vld && !exe_wr && (cand_idx == CW'(c));

      wb_chan_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) u_fifo (
         .clk       (clk),
         .rst       (rst),
         .push      (push[c]),
         .push_rd   (rd_c),
         .push_data (lc_data[c*XLEN +: XLEN]),
         .pop       (pop[c]),
         .full      (full[c]),
         .empty     (empty[c]),
         .head_rd   (head_rd[c]),
         .head_data (head_data[c]),
         .ent_vld   (ent_vld[c]),
         .ent_rd    (ent_rd[c])
      );

      a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(lc_vld[c] && !lc_rdy[c]));
   end

   // First non-empty channel at or after rr_ptr; only used when EXE leaves the port free.
   always_comb begin
      cand_vld = 1'b0;
      cand_idx = '0;
      for (int k = 0; k < NCH; k++) begin
         if (!cand_vld && !empty[(int'(rr_ptr) + k) % NCH]) begin
            cand_vld = 1'b1;
            cand_idx = CW'((int'(rr_ptr) + k) % NCH);
         end
      end
   end

   always_comb begin
      pend_mask = '0;
      for (int c = 0; c < NCH; c++)
         for (int i = 0; i < DEPTH; i++)
            if (ent_vld[c][i]) pend_mask |= onehot32(ent_rd[c][i]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_wr   <= 1'b0;
         rf_rd   <= '0;
         rf_data <= '0;
         rr_ptr  <= '0;
      end else if (exe_wr) begin
         rf_wr   <= 1'b1;
         rf_rd   <= exe_rd;
         rf_data <= exe_data;
      end else if (cand_vld) begin
         rf_wr   <= 1'b1;
         rf_rd   <= head_rd[cand_idx];
         rf_data <= head_data[cand_idx];
         rr_ptr  <= (cand_idx == CW'(NCH-1)) ? '0 : cand_idx + 1'b1;
      end else begin
         rf_wr   <= 1'b0;
      end
   end

`ifdef WB_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_starve_cnt <= '0;
         perf_full_cnt   <= '0;
      end else begin
         if (cand_vld && exe_wr && perf_starve_cnt != '1) perf_starve_cnt <= perf_starve_cnt + 1'b1;
         if (!(&lc_rdy) && perf_full_cnt != '1)           perf_full_cnt   <= perf_full_cnt + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed + random bench for wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;
   import wb_pkg::*;

   localparam int XLEN  = 32;
   localparam int NCH   = 2;
   localparam int DEPTH = 2;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                exe_vld = 1'b0;
   logic [4:0]          exe_rd = '0;
   logic [XLEN-1:0]     exe_data = '0;
   logic [NCH-1:0]      lc_vld = '0;
   logic [NCH*5-1:0]    lc_rd = '0;
   logic [NCH*XLEN-1:0] lc_data = '0;
   logic [NCH-1:0]      lc_rdy;
   logic                rf_wr;
   logic [4:0]          rf_rd;
   logic [XLEN-1:0]     rf_data;
   logic [31:0]         pend_mask;
`ifdef WB_PERF_EN
   logic [31:0]         perf_starve_cnt, perf_full_cnt;
`endif

   always #5 clk = ~clk;

   wb_arbiter #(.XLEN(XLEN), .NCH(NCH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .exe_vld   (exe_vld),
      .exe_rd    (exe_rd),
      .exe_data  (exe_data),
      .lc_vld    (lc_vld),
      .lc_rd     (lc_rd),
      .lc_data   (lc_data),
      .lc_rdy    (lc_rdy),
      .rf_wr     (rf_wr),
      .rf_rd     (rf_rd),
      .rf_data   (rf_data),
      .pend_mask (pend_mask)
`ifdef WB_PERF_EN
      ,
      .perf_starve_cnt (perf_starve_cnt),
      .perf_full_cnt   (perf_full_cnt)
`endif
   );

   // Reference: one queue of results per channel, a round-robin start index, expected port state.
   wb_entry_t   q[NCH][$];
   int          m_rr = 0;
   logic        exp_wr = 1'b0;
   logic [4:0]  exp_rd = '0;
   logic [31:0] exp_data = '0;
   logic [4:0]  wr_log[$];
   int          n_tot = 0;
   int          n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   task automatic model_step();
      int        sz[NCH];
      bit        got = 0;
      wb_entry_t e;
      if (rst) begin
         for (int c = 0; c < NCH; c++) q[c].delete();
         m_rr = 0; exp_wr = 1'b0; exp_rd = '0; exp_data = '0;
         return;
      end
      for (int c = 0; c < NCH; c++) sz[c] = q[c].size();
      exp_wr = 1'b0;
      if (exe_vld && exe_rd != 0) begin
         exp_wr = 1'b1; exp_rd = exe_rd; exp_data = exe_data;
      end else begin
         for (int k = 0; k < NCH; k++) begin
            int c;
            c = (m_rr + k) % NCH;
            if (!got && q[c].size() > 0) begin
               got = 1;
               e = q[c].pop_front();
               exp_wr = 1'b1; exp_rd = e.rd; exp_data = e.data;
               m_rr = (c + 1) % NCH;
            end
         end
      end
      for (int c = 0; c < NCH; c++) begin
         if (lc_vld[c] && sz[c] < DEPTH && lc_rd[c*5 +: 5] != 0) begin
            e.rd = lc_rd[c*5 +: 5];
            e.data = lc_data[c*XLEN +: XLEN];
            q[c].push_back(e);
         end
      end
   endtask

   task automatic cyc(input string tag);
      logic [31:0]    pm = '0;
      logic [NCH-1:0] rdy;
      model_step();
      @(posedge clk); #1;
      for (int c = 0; c < NCH; c++) begin
         for (int i = 0; i < q[c].size(); i++) pm |= 32'd1 << q[c][i].rd;
         rdy[c] = !rst && (q[c].size() < DEPTH);
      end
      chk({tag, ".rf_wr"},   64'(rf_wr),     64'(exp_wr));
      chk({tag, ".rf_rd"},   64'(rf_rd),     64'(exp_rd));
      chk({tag, ".rf_data"}, 64'(rf_data),   64'(exp_data));
      chk({tag, ".pend"},    64'(pend_mask), 64'(pm));
      chk({tag, ".lc_rdy"},  64'(lc_rdy),    64'(rdy));
      if (rf_wr) wr_log.push_back(rf_rd);
   endtask

   task automatic idle();
      exe_vld = 1'b0;
      lc_vld  = '0;
   endtask

   task automatic set_exe(input logic [4:0] rd, input logic [31:0] d);
      exe_vld = 1'b1; exe_rd = rd; exe_data = d;
   endtask

   task automatic set_lc(input int c, input logic [4:0] rd, input logic [31:0] d);
      lc_vld[c] = 1'b1;
      lc_rd[c*5 +: 5] = rd;
      lc_data[c*XLEN +: XLEN] = d;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      cyc("reset");
      rst = 1'b0;
   endtask

   logic [4:0] rr_exp[4] = '{5'd1, 5'd3, 5'd2, 5'd4};

   initial begin
      // Reset state
      do_reset();
      chk("reset.pend_const", 64'(pend_mask), 64'd0);
      chk("reset.wr_const",   64'(rf_wr),     64'd0);

      // Round-robin: fill both channels behind EXE traffic, then drain
      set_exe(5'd9, 32'h9); set_lc(0, 5'd1, 32'h101); set_lc(1, 5'd3, 32'h303);
      cyc("rr_fill0");
      set_lc(0, 5'd2, 32'h202); set_lc(1, 5'd4, 32'h404);
      cyc("rr_fill1");
      chk("rr.full_rdy", 64'(lc_rdy), 64'd0);
      idle(); wr_log.delete();
      repeat (5) cyc("rr_drain");
      chk("rr.count", 64'(wr_log.size()), 64'd4);
      for (int i = 0; i < 4 && i < wr_log.size(); i++) chk("rr.order", 64'(wr_log[i]), 64'(rr_exp[i]));

      // EXE priority with a simultaneous channel push, then x0 EXE filter
      set_exe(5'd5, 32'h1234); set_lc(0, 5'd7, 32'hBEEF);
      cyc("exe_pri");
      chk("exe_pri.rd_const", 64'(rf_rd), 64'd5);
      idle();
      cyc("exe_pri_lc");
      chk("exe_pri_lc.rd_const",   64'(rf_rd),   64'd7);
      chk("exe_pri_lc.data_const", 64'(rf_data), 64'hBEEF);
      set_exe(5'd0, 32'hDEAD);
      cyc("exe_x0");
      chk("exe_x0.wr_const", 64'(rf_wr), 64'd0);

      // x0 long-latency discard
      idle(); set_lc(0, 5'd0, 32'hCAFE);
      cyc("lc_x0");
      chk("lc_x0.pend_const", 64'(pend_mask), 64'd0);
      idle();
      repeat (3) cyc("lc_x0_idle");

      // Backpressure on channel 1 under continuous EXE writes
      set_exe(5'd10, 32'hA0); set_lc(1, 5'd11, 32'hB11);
      cyc("bp0");
      set_lc(1, 5'd12, 32'hB12);
      cyc("bp1");
      lc_vld = '0;
      cyc("bp2");
      chk("bp.rdy1_const", 64'(lc_rdy[1]), 64'd0);
      chk("bp.pend_const", 64'(pend_mask), 64'h1800);
      idle();
      cyc("bp_drain0");
      chk("bp.rdy_after_pop", 64'(lc_rdy[1]), 64'd1);
      chk("bp.first_rd",      64'(rf_rd),     64'd11);
      cyc("bp_drain1");
      cyc("bp_drain2");

      // Reset mid-operation with three entries buffered and rr_ptr away from 0
      set_lc(0, 5'd13, 32'hD13);
      cyc("mr0");
      set_lc(0, 5'd14, 32'hD14); set_lc(1, 5'd15, 32'hD15);
      cyc("mr1");
      lc_vld = '0; set_exe(5'd20, 32'hE20); set_lc(0, 5'd16, 32'hD16);
      cyc("mr2");
      do_reset();
      chk("mr.pend_const", 64'(pend_mask), 64'd0);
      chk("mr.wr_const",   64'(rf_wr),     64'd0);
      wr_log.delete();
      repeat (2) cyc("mr_idle");
      set_lc(0, 5'd17, 32'hD17); set_lc(1, 5'd18, 32'hD18);
      cyc("mr_push");
      idle();
      repeat (3) cyc("mr_drain");
      chk("mr.count", 64'(wr_log.size()), 64'd2);
      if (wr_log.size() >= 2) begin
         chk("mr.first",  64'(wr_log[0]), 64'd17);
         chk("mr.second", 64'(wr_log[1]), 64'd18);
      end

      // Random traffic; pushes only offered where the model says the channel is ready
      for (int n = 0; n < 400; n++) begin
         exe_vld  = ($urandom_range(0, 2) == 0);
         exe_rd   = 5'($urandom_range(0, 31));
         exe_data = $urandom;
         for (int c = 0; c < NCH; c++) begin
            if (q[c].size() < DEPTH && $urandom_range(0, 2) != 0)
               set_lc(c, 5'($urandom_range(0, 31)), $urandom);
            else
               lc_vld[c] = 1'b0;
         end
         cyc("rand");
      end
      idle();
      repeat (6) cyc("rand_drain");

`ifdef WB_PERF_EN
      do_reset();
      set_exe(5'd21, 32'hF0); set_lc(0, 5'd22, 32'hF1);
      cyc("perf_push");
      lc_vld = '0;
      repeat (10) cyc("perf_starve");
      chk("perf.starve", 64'(perf_starve_cnt), 64'd10);
      chk("perf.full",   64'(perf_full_cnt),   64'd0);
      idle();
      repeat (2) cyc("perf_drain");
`endif

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
